// File: rtl/record_pkg.sv
// Shared types and defaults for the record-digit conversion path.
package record_pkg;

   localparam int REC_BIN_W   = 24;
   localparam int REC_NDIG    = 7;
   localparam int REC_MAX_VAL = 9999999;
   localparam int REC_CNT_W   = $clog2(REC_BIN_W + 1);

   typedef logic [3:0] bcd_nibble_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } rec_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One shift-add-3 step: correct every nibble >= 5 by +3, then shift in one bit.
module bcd_dabble_step
   import record_pkg::*;
#(
   parameter int NDIG = REC_NDIG
) (
   input  logic [NDIG*4-1:0] acc,
   input  logic              bit_in,
   output logic [NDIG*4-1:0] acc_next
);

   // NOTE: every variable gets a value before any branch, so no latch is inferred.
   always_comb begin
      bcd_nibble_t fixed;
      logic        carry;
      acc_next = '0;
      carry    = bit_in;
      for (int i = 0; i < NDIG; i++) begin
         fixed = acc[i*4 +: 4];
         if (fixed >= 4'd5) begin
            fixed = fixed + 4'd3;
         end
         acc_next[i*4 +: 4] = {fixed[2:0], carry};
         carry = fixed[3];
      end
   end

endmodule

// File: rtl/record_bcd_latch.sv
// Latches a binary record, converts it to BCD serially and publishes the digits
// only once the conversion is complete.
module record_bcd_latch
   import record_pkg::*;
#(
   parameter int BIN_W   = REC_BIN_W,
   parameter int NDIG    = REC_NDIG,
   parameter int MAX_VAL = REC_MAX_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rec_valid,
   input  logic [BIN_W-1:0] rec_value,
   input  logic             rec_clear,
   output logic             busy,
   output logic             has_record,
   output logic [3:0]       led1,
   output logic [3:0]       led2,
   output logic [3:0]       led3,
   output logic [3:0]       led4,
   output logic [3:0]       led5,
   output logic [3:0]       led6,
   output logic [3:0]       led7
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int ACC_W = NDIG * 4;

   rec_state_t       state, state_next;
   logic [BIN_W-1:0] bin_sr;
   logic [ACC_W-1:0] bcd_acc;
   logic [ACC_W-1:0] bcd_step;
   logic [ACC_W-1:0] shown;
   logic [CNT_W-1:0] bit_cnt;
   logic [BIN_W-1:0] sat_value;
   logic             last_step;

   assign sat_value = (rec_value > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : rec_value;
   assign last_step = (bit_cnt == CNT_W'(BIN_W - 1));

   bcd_dabble_step #(.NDIG(NDIG)) u_step (
      .acc      (bcd_acc),
      .bit_in   (bin_sr[BIN_W-1]),
      .acc_next (bcd_step)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (rec_valid) state_next = SHIFT;
         SHIFT:   if (last_step) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (rec_clear) begin
         state_next = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Working registers and the displayed digits share one abort path: a clear
   // throws away any partial result so it can never be committed.
   always_ff @(posedge clk) begin
      if (rst || rec_clear) begin
         bin_sr     <= '0;
         bcd_acc    <= '0;
         bit_cnt    <= '0;
         shown      <= '0;
         has_record <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rec_valid) begin
                  bin_sr  <= sat_value;
                  bcd_acc <= '0;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               bcd_acc <= bcd_step;
               bin_sr  <= bin_sr << 1;
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            COMMIT: begin
               shown      <= bcd_acc;
               has_record <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign led1 = shown[3:0];
   assign led2 = shown[7:4];
   assign led3 = shown[11:8];
   assign led4 = shown[15:12];
   assign led5 = shown[19:16];
   assign led6 = shown[23:20];
   assign led7 = shown[27:24];

endmodule

// File: tb/tb_record_bcd_latch.sv
// Self-checking bench: a countdown/decimal-arithmetic model is compared with the
// DUT every cycle, plus literal expectations at the key directed points.
module tb_record_bcd_latch;
   localparam int BIN_W   = 24;
   localparam int MAX_VAL = 9999999;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rec_valid = 1'b0;
   logic [BIN_W-1:0] rec_value = '0;
   logic             rec_clear = 1'b0;
   logic             busy, has_record;
   logic [3:0]       led1, led2, led3, led4, led5, led6, led7;

   int n_checks = 0;
   int n_err    = 0;
   bit compare_on = 1'b0;

   record_bcd_latch dut (
      .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_value(rec_value),
      .rec_clear(rec_clear), .busy(busy), .has_record(has_record),
      .led1(led1), .led2(led2), .led3(led3), .led4(led4),
      .led5(led5), .led6(led6), .led7(led7)
   );

   always #5 clk = ~clk;

   wire [27:0] leds = {led7, led6, led5, led4, led3, led2, led1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] to_bcd(input int unsigned v);
      logic [27:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 0; i < 7; i++) begin
         r[i*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Model: a record accepted while idle appears BIN_W+1 edges later.
   int unsigned m_val    = 0;
   int unsigned m_pend   = 0;
   bit          m_has    = 1'b0;
   int          m_remain = 0;

   always @(posedge clk) begin
      if (rst || rec_clear) begin
         m_val    = 0;
         m_has    = 1'b0;
         m_remain = 0;
      end else if (m_remain == 0) begin
         if (rec_valid) begin
            m_pend   = (int'(rec_value) > MAX_VAL) ? MAX_VAL : int'(rec_value);
            m_remain = BIN_W + 1;
         end
      end else begin
         m_remain--;
         if (m_remain == 0) begin
            m_val = m_pend;
            m_has = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (compare_on) begin
         check("busy", {31'd0, busy}, {31'd0, m_remain != 0});
         check("has_record", {31'd0, has_record}, {31'd0, m_has});
         check("leds", {4'd0, leds}, {4'd0, to_bcd(m_val)});
      end
   end

   task automatic strobe(input int unsigned v);
      @(negedge clk);
      rec_valid = 1'b1;
      rec_value = BIN_W'(v);
      @(negedge clk);
      rec_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   function automatic int unsigned rand_value();
      case ($urandom_range(0, 3))
         0: return $urandom_range(0, 32'hFFFFFF);
         1: return $urandom_range(0, 999);
         2: return MAX_VAL - 1 + $urandom_range(0, 2);
         default: return $urandom_range(0, MAX_VAL);
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare_on = 1'b1;
      repeat (10) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_has", {31'd0, has_record}, 32'd0);
      check("reset_leds", {4'd0, leds}, 32'd0);

      // 1234567: busy through edges k..k+24, digits appear at k+25
      strobe(1234567);
      check("conv_busy_k", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         check("conv_busy_mid", {31'd0, busy}, 32'd1);
         check("conv_leds_hold", {4'd0, leds}, 32'd0);
      end
      @(negedge clk);
      check("commit_leds", {4'd0, leds}, 32'h1234567);
      check("commit_has", {31'd0, has_record}, 32'd1);
      check("commit_busy", {31'd0, busy}, 32'd0);

      strobe(16777215);
      wait_idle();
      check("saturate", {4'd0, leds}, 32'h9999999);
      strobe(0);
      wait_idle();
      check("zero_leds", {4'd0, leds}, 32'h0);
      check("zero_has", {31'd0, has_record}, 32'd1);

      strobe(42);
      wait_idle();
      check("rec_42", {4'd0, leds}, 32'h42);
      strobe(555);
      @(negedge clk);
      strobe(777);
      wait_idle();
      repeat (30) @(negedge clk);
      check("ignore_busy", {4'd0, leds}, 32'h555);

      // clear sampled at edge k+10 of a conversion
      strobe(9876543);
      repeat (9) @(negedge clk);
      rec_clear = 1'b1;
      @(negedge clk);
      rec_clear = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_has", {31'd0, has_record}, 32'd0);
      check("abort_leds", {4'd0, leds}, 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_commit", {3'd0, has_record, leds}, 32'd0);

      strobe(100);
      wait_idle();
      check("rec_100", {4'd0, leds}, 32'h100);
      @(negedge clk);
      rec_valid = 1'b1;
      rec_clear = 1'b1;
      rec_value = BIN_W'(321);
      @(negedge clk);
      rec_valid = 1'b0;
      rec_clear = 1'b0;
      check("clr_wins_busy", {31'd0, busy}, 32'd0);
      check("clr_wins_has", {31'd0, has_record}, 32'd0);
      @(negedge clk);
      check("clr_wins_idle", {3'd0, busy, leds}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 299) == 0);
         rec_clear = ($urandom_range(0, 59) == 0);
         rec_valid = ($urandom_range(0, 5) == 0);
         rec_value = BIN_W'(rand_value());
      end
      @(negedge clk);
      rst = 1'b0;
      rec_clear = 1'b0;
      rec_valid = 1'b0;
      repeat (30) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/record_bcd_latch.md
Name: record_bcd_latch

Overview:
- Upstream feeder of the VGA record-digit renderer.
- Accepts a binary record value (e.g. best score or elapsed count) on a one-cycle strobe.
- Converts it sequentially (shift-add-3, one bit per clock) into 7 BCD digits and holds them for display, together with a has_record flag.
- Displayed digits never change mid-conversion, so the renderer never shows partial values.

Parameters:
- BIN_W, 24, width of binary input value.
- NDIG, 7, number of BCD output digits; fixed by the renderer's led1..led7.
- MAX_VAL, 9999999, saturation ceiling; inputs above this are converted as MAX_VAL.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rec_valid  in  1  one-cycle strobe: rec_value is a new record
- rec_value  in  BIN_W  binary record value
- rec_clear  in  1  synchronous erase of stored record
- busy  out  1  conversion in progress; new strobes are ignored while high
- has_record  out  1  a valid record is held
- led1  out  4  BCD digit, least significant (units)
- led2..led6  out  4 each  BCD digits, ascending significance
- led7  out  4  BCD digit, most significant (10^6)

Behaviour:
- Reset and clear:
  - Reset values: busy=0, has_record=0, led1..led7=0, FSM=IDLE, shift/BCD working registers=0.
  - rec_clear has priority over everything except rst. At the clock edge it aborts any conversion, then FSM=IDLE, busy=0, has_record=0, all leds=0.
  - rst or rec_clear asserted mid-conversion: the partial result is discarded and never reaches the outputs.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - On rec_valid=1 and rec_clear=0 at edge k: load the binary shift register with min(rec_value, MAX_VAL). Clear the BCD accumulator (NDIG*4 bits) and bit counter. Go to SHIFT. busy=1 after edge k.
- SHIFT:
  - Each edge: every BCD nibble >=5 gets +3.
  - Then {bcd, bin} shifts left by 1, MSB of bin entering bcd LSB.
  - Counter increments each edge. After BIN_W steps (edges k+1..k+BIN_W), go to COMMIT.
- COMMIT, edge k+BIN_W+1 (k+25 at defaults):
  - led1..led7 <= accumulator nibbles 0..6.
  - has_record <= 1, busy <= 0, FSM <= IDLE.
- Latency: outputs update exactly BIN_W+1 edges after the accepting edge. Throughput: one record per BIN_W+2 cycles; IDLE lasts at least one cycle.
- Output stability: led1..led7 and has_record hold their previous values throughout SHIFT. They change only at COMMIT, clear or reset.
- rec_valid while busy: ignored and not queued. rec_valid in the same cycle as COMMIT is also ignored, because the FSM is not yet in IDLE.
- rec_valid together with rec_clear: clear wins and the strobe is dropped.
- Saturation compare is unsigned. Value 0 is a legal record: all zero digits, has_record=1.
- Every nibble is 0..9 after COMMIT. Upper nibbles above a value's magnitude are 0; there is no leading-blank encoding.

Decomposition:
- Shared package record_pkg:
  - FSM state enum {IDLE, SHIFT, COMMIT}
  - BIN_W, NDIG, MAX_VAL defaults
  - BCD nibble typedef (4-bit)
  - counter width constant $clog2(BIN_W+1)
- One natural combinational sub-module, bcd_dabble_step:
  - Input NDIG*4-bit accumulator plus incoming bit; output the corrected-and-shifted accumulator.
  - Per nibble: +3 if >=5, then shift.
  - Reusable by the score/time display paths.

Test Plan:
- Reset then idle 10 cycles -> busy=0, has_record=0, led1..led7=0 throughout.
- rec_value=1234567, rec_valid pulse at edge k:
  - busy=1 on edges k..k+24, leds stay 0 during that time.
  - At edge k+25: led7..led1=1,2,3,4,5,6,7, has_record=1, busy=0.
- rec_value=16777215 -> saturates, leds=9999999 all nines. Then rec_value=0 -> all leds 0, has_record stays 1.
- First record 42 committed; strobe 555 then 777 two cycles later while busy -> final leds=0000555; 777 never appears.
- Mid-conversion rec_clear at edge k+10 of a 9876543 conversion -> has_record=0, leds=0, busy=0 next cycle. No commit occurs at k+25.
- rec_valid and rec_clear in the same cycle with prior record 100 -> record erased, no conversion started, busy stays 0.
